// File: rtl/pipelined_cla_adder.sv
// Pipelined carry-lookahead adder/subtractor, one GROUP-bit lookahead group per stage.
// Define CLA_ADDER_FLAGS_EN to build the registered ovf and zero flags.
module pipelined_cla_adder #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   localparam int L = WIDTH / GROUP;

   logic             en;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   assign b_eff = b ^ {WIDTH{sub}};
   assign c_eff = cin ^ sub;

   // Each carry is a flat sum of products: no carry feeds another carry.
   function automatic logic [GROUP:0] cla(
      input logic [GROUP-1:0] p,
      input logic [GROUP-1:0] g,
      input logic             ci
   );
      logic [GROUP:0] c;
      logic           t;
      logic           pr;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
         t = ci;
         for (int j = 0; j <= i; j++)
            t = t & p[j];
         for (int j = 0; j <= i; j++) begin
            pr = g[j];
            for (int m = j + 1; m <= i; m++)
               pr = pr & p[m];
            t = t | pr;
         end
         c[i+1] = t;
      end
      return c;
   endfunction

   genvar k;
   generate
      for (k = 0; k < L; k++) begin : stg
         localparam int RW = WIDTH - k * GROUP;
         localparam int SW = (k + 1) * GROUP;

         logic [RW-1:0]    src_a;
         logic [RW-1:0]    src_b;
         logic             src_c;
         logic             src_v;
         logic [GROUP-1:0] p;
         logic [GROUP-1:0] g;
         logic [GROUP:0]   cc;
         logic [GROUP-1:0] gs;
         logic [SW-1:0]    nxt_s;
         logic             v_q;
         logic             c_q;
         logic [SW-1:0]    s_q;

         if (k == 0) begin : head
            assign src_a = a;
            assign src_b = b_eff;
            assign src_c = c_eff;
            assign src_v = in_valid;
            assign nxt_s = gs;
         end else begin : body
            assign src_a = stg[k-1].fwd.a_q;
            assign src_b = stg[k-1].fwd.b_q;
            assign src_c = stg[k-1].c_q;
            assign src_v = stg[k-1].v_q;
            assign nxt_s = {gs, stg[k-1].s_q};
         end

         assign p  = src_a[GROUP-1:0] ^ src_b[GROUP-1:0];
         assign g  = src_a[GROUP-1:0] & src_b[GROUP-1:0];
         assign cc = cla(p, g, src_c);
         assign gs = p ^ cc[GROUP-1:0];

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               v_q <= 1'b0;
               c_q <= 1'b0;
               s_q <= '0;
            end else if (en) begin
               v_q <= src_v;
               c_q <= cc[GROUP];
               s_q <= nxt_s;
            end
         end

         // Only the not-yet-resolved operand groups travel forward.
         if (k < L - 1) begin : fwd
            logic [RW-GROUP-1:0] a_q;
            logic [RW-GROUP-1:0] b_q;
            always_ff @(posedge clk or negedge rst_n) begin
               if (!rst_n) begin
                  a_q <= '0;
                  b_q <= '0;
               end else if (en) begin
                  a_q <= src_a[RW-1:GROUP];
                  b_q <= src_b[RW-1:GROUP];
               end
            end
         end
      end
   endgenerate

   assign out_valid = stg[L-1].v_q;
   assign sum       = stg[L-1].s_q;
   assign cout      = stg[L-1].c_q;
   assign en        = !out_valid || out_ready;
   assign in_ready  = en;

`ifdef CLA_ADDER_FLAGS_EN
   logic ovf_q;
   logic zero_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf_q  <= 1'b0;
         zero_q <= 1'b0;
      end else if (en) begin
         ovf_q  <= stg[L-1].cc[GROUP-1] ^ stg[L-1].cc[GROUP];
         zero_q <= ~|stg[L-1].nxt_s;
      end
   end

   assign ovf  = ovf_q;
   assign zero = zero_q;
`else
   assign ovf  = 1'b0;
   assign zero = 1'b0;
`endif

endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Randomised and directed bench for pipelined_cla_adder against an
// arithmetic reference model behind a latency-L elastic line.
module tb_pipelined_cla_adder;

   localparam int W = 16;
   localparam int G = 4;
   localparam int L = W / G;

   logic         clk;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         cin;
   logic         sub;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] sum;
   logic         cout;
   logic         ovf;
   logic         zero;

   int nvec = 0;
   int nerr = 0;

   logic         mv [L];
   logic [W+2:0] mr [L];

   pipelined_cla_adder #(.WIDTH(W), .GROUP(G)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .cin       (cin),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .cout      (cout),
      .ovf       (ovf),
      .zero      (zero)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // {ovf, zero, cout, sum}
   function automatic logic [W+2:0] ref_res(
      input logic [W-1:0] x,
      input logic [W-1:0] y,
      input logic         ci,
      input logic         sb
   );
      logic [W-1:0] be;
      logic [W:0]   t;
      logic         o;
      logic         z;
      be = sb ? ~y : y;
      t  = {1'b0, x} + {1'b0, be} + (W+1)'(ci ^ sb);
      o  = (x[W-1] == be[W-1]) && (t[W-1] != x[W-1]);
      z  = (t[W-1:0] == '0);
`ifndef CLA_ADDER_FLAGS_EN
      o = 1'b0;
      z = 1'b0;
`endif
      return {o, z, t};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic clear_model();
      for (int i = 0; i < L; i++) begin
         mv[i] = 1'b0;
         mr[i] = '0;
      end
   endtask

   task automatic check_out();
      chk("out_valid", 32'(out_valid), 32'(mv[L-1]));
      if (mv[L-1]) begin
         chk("sum",  32'(sum),  32'(mr[L-1][W-1:0]));
         chk("cout", 32'(cout), 32'(mr[L-1][W]));
         chk("zero", 32'(zero), 32'(mr[L-1][W+1]));
         chk("ovf",  32'(ovf),  32'(mr[L-1][W+2]));
      end
   endtask

   // Called just after a falling edge; returns just after the next one.
   task automatic cycle(
      input logic         iv,
      input logic [W-1:0] ia,
      input logic [W-1:0] ib,
      input logic         ic,
      input logic         is,
      input logic         orr
   );
      logic en;
      in_valid  = iv;
      a         = ia;
      b         = ib;
      cin       = ic;
      sub       = is;
      out_ready = orr;
      #1;
      en = !mv[L-1] || orr;
      chk("in_ready", 32'(in_ready), 32'(en));
      @(posedge clk);
      if (en) begin
         for (int i = L - 1; i > 0; i--) begin
            mv[i] = mv[i-1];
            mr[i] = mr[i-1];
         end
         mv[0] = iv;
         mr[0] = ref_res(ia, ib, ic, is);
      end
      @(negedge clk);
      check_out();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++)
         cycle(1'b0, '0, '0, 1'b0, 1'b0, 1'b1);
   endtask

   task automatic rnd_beat(input logic orr);
      cycle(1'b1, W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), orr);
   endtask

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
      chk({tag, "_sum"},       32'(sum),       32'd0);
      chk({tag, "_cout"},      32'(cout),      32'd0);
      chk({tag, "_ovf"},       32'(ovf),       32'd0);
      chk({tag, "_zero"},      32'(zero),      32'd0);
      chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
   endtask

   initial begin
      logic exp_flag;
      rst_n     = 1'b0;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      cin       = 1'b0;
      sub       = 1'b0;
      out_ready = 1'b1;
      clear_model();

      @(negedge clk);
      check_reset_outputs("reset");
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      // 0xFFFF + 1 wraps to zero with carry out, visible after L edges
      cycle(1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      idle(L - 1);
`ifdef CLA_ADDER_FLAGS_EN
      exp_flag = 1'b1;
`else
      exp_flag = 1'b0;
`endif
      chk("wrap_valid", 32'(out_valid), 32'd1);
      chk("wrap_sum",   32'(sum),       32'h0000);
      chk("wrap_cout",  32'(cout),      32'd1);
      chk("wrap_zero",  32'(zero),      32'(exp_flag));

      cycle(1'b1, 16'h0005, 16'h0007, 1'b0, 1'b1, 1'b1);
      idle(L - 1);
      chk("sub_sum",  32'(sum),  32'hFFFE);
      chk("sub_cout", 32'(cout), 32'd0);
      chk("sub_ovf",  32'(ovf),  32'd0);
      chk("sub_zero", 32'(zero), 32'd0);

      cycle(1'b1, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 1'b1);
      idle(L - 1);
      chk("ovf_sum",  32'(sum),  32'h8000);
      chk("ovf_cout", 32'(cout), 32'd0);
      chk("ovf_ovf",  32'(ovf),  32'(exp_flag));
      idle(1);

      for (int i = 0; i < 16; i++)
         rnd_beat(1'b1);
      idle(L + 1);

      // Backpressure: pipeline fills, then stalls, then drains in order
      for (int i = 0; i < 6; i++)
         rnd_beat(1'b0);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      idle(L + 2);

      for (int i = 0; i < 300; i++)
         cycle(1'($urandom_range(0, 3) != 0), W'($urandom), W'($urandom),
               1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));
      idle(L + 1);

      // Reset with a full pipeline: everything discarded at once
      for (int i = 0; i < L; i++)
         rnd_beat(1'b0);
      rst_n = 1'b0;
      #1;
      clear_model();
      check_reset_outputs("midrst");
      @(posedge clk);
      @(negedge clk);
      check_reset_outputs("midrst_hold");
      rst_n = 1'b1;

      cycle(1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1);
      idle(L - 1);
      chk("post_rst_valid", 32'(out_valid), 32'd1);
      chk("post_rst_sum",   32'(sum),       32'h5556);
      chk("post_rst_cout",  32'(cout),      32'd0);
      idle(2);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
